forward_unit: RTL

FORWARD_UNIT -- requirements
Module: forward_unit

---
 rtl/forward_unit_pkg.sv | 14 +
 rtl/forward_unit_compare.sv | 25 ++
 rtl/forward_unit.sv | 104 ++++++++++
 3 files changed

// File: rtl/forward_unit_pkg.sv
// forward_unit_pkg: operand-select encodings and pipeline stage record shared by the forwarding unit.
package forward_unit_pkg;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_MEMWB   = 2'b10;

    typedef struct packed {
        logic valid;
        logic we;
        logic ld;
    } stage_t;

endpackage

// File: rtl/forward_unit_compare.sv
// fwd_compare: one EX operand select from the MEM and WB producers, newest producer first.
module fwd_compare
    import forward_unit_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] ex_rs,
    input  stage_t            mem_st,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_valid,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        sel
);

    logic mem_hit, wb_hit;

    // a load still in MEM has no data yet; the load-use stall keeps this case from arising
    always_comb begin
        mem_hit = mem_st.valid && mem_st.we && !mem_st.ld && mem_rd != '0 && mem_rd == ex_rs;
        wb_hit  = wb_valid && wb_we && wb_rd != '0 && wb_rd == ex_rs;
        sel     = mem_hit ? FWD_EXMEM : wb_hit ? FWD_MEMWB : FWD_REGFILE;
    end

endmodule

// File: rtl/forward_unit.sv
// forward_unit: EX/MEM/WB hazard tracking, operand forwarding and load-use stall; FORWARD_UNIT_STATS_EN builds the stall counter.
module forward_unit
    import forward_unit_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [REG_AW-1:0] ID_RS1,
    input  logic [REG_AW-1:0] ID_RS2,
    input  logic [REG_AW-1:0] ID_RD,
    input  logic              ID_REG_WRITE,
    input  logic              ID_MEM_READ,
    input  logic              FLUSH,
    input  logic              BUSYWAIT,
    output logic [1:0]        FWD_SEL_A,
    output logic [1:0]        FWD_SEL_B,
    output logic              STALL,
    output logic [CNT_W-1:0]  STALL_COUNT
);

    stage_t            ex_q, ex_d, mem_q, mem_d;
    logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_rd_q, ex_rd_d;
    logic [REG_AW-1:0] mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
    logic              wb_valid_q, wb_valid_d, wb_we_q, wb_we_d;
    logic              bubble;

    always_comb begin
        STALL      = !FLUSH && ex_q.valid && ex_q.ld && ex_rd_q != '0
                     && (ex_rd_q == ID_RS1 || ex_rd_q == ID_RS2);
        bubble     = FLUSH || STALL;
        ex_d       = ex_q;
        ex_rs1_d   = ex_rs1_q;
        ex_rs2_d   = ex_rs2_q;
        ex_rd_d    = ex_rd_q;
        mem_d      = mem_q;
        mem_rd_d   = mem_rd_q;
        wb_valid_d = wb_valid_q;
        wb_we_d    = wb_we_q;
        wb_rd_d    = wb_rd_q;
        if (!BUSYWAIT) begin
            ex_d       = bubble ? stage_t'('0) : stage_t'{valid: 1'b1, we: ID_REG_WRITE, ld: ID_MEM_READ};
            ex_rs1_d   = bubble ? '0 : ID_RS1;
            ex_rs2_d   = bubble ? '0 : ID_RS2;
            ex_rd_d    = bubble ? '0 : ID_RD;
            mem_d      = ex_q;
            mem_rd_d   = ex_rd_q;
            wb_valid_d = mem_q.valid;
            wb_we_d    = mem_q.we;
            wb_rd_d    = mem_rd_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ex_q       <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            ex_rd_q    <= '0;
            mem_q      <= '0;
            mem_rd_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
        end else begin
            ex_q       <= ex_d;
            ex_rs1_q   <= ex_rs1_d;
            ex_rs2_q   <= ex_rs2_d;
            ex_rd_q    <= ex_rd_d;
            mem_q      <= mem_d;
            mem_rd_q   <= mem_rd_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
        end
    end

    fwd_compare #(.REG_AW(REG_AW)) u_cmp_a (
        .ex_rs(ex_rs1_q), .mem_st(mem_q), .mem_rd(mem_rd_q),
        .wb_valid(wb_valid_q), .wb_we(wb_we_q), .wb_rd(wb_rd_q), .sel(FWD_SEL_A)
    );

    fwd_compare #(.REG_AW(REG_AW)) u_cmp_b (
        .ex_rs(ex_rs2_q), .mem_st(mem_q), .mem_rd(mem_rd_q),
        .wb_valid(wb_valid_q), .wb_we(wb_we_q), .wb_rd(wb_rd_q), .sel(FWD_SEL_B)
    );

`ifdef FORWARD_UNIT_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = cnt_q + CNT_W'(!BUSYWAIT && STALL);

    always_ff @(posedge CLK) begin
        if (RESET) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign STALL_COUNT = cnt_q;
`else
    assign STALL_COUNT = '0;
`endif

endmodule
